// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end framing {cmd, payload} for the RAM controller and returning read data on MISO.
module spi_slave_ctrl #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam int CW = $clog2(DATA_W + 2);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [TW-1:0]     tmo, tmo_n;
    logic [DATA_W+1:0] rx_n, rx_shift;
    logic [DATA_W-1:0] sh, sh_n;
    logic [1:0]        cmd;
    logic              oe_n, rd_addr_seen, seen_n, rxv_n, err_n;

    assign rx_shift = {rx_data[DATA_W:0], MOSI};
    assign cmd      = rx_shift[DATA_W+1:DATA_W];
    assign busy     = state != IDLE;
    assign MISO     = miso_oe & sh[DATA_W-1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmo_n   = tmo;
        rx_n    = rx_data;
        sh_n    = sh;
        oe_n    = miso_oe;
        seen_n  = rd_addr_seen;
        rxv_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (!SS_n) begin
                state_n = RX;
                cnt_n   = '0;
            end
            RX: if (SS_n) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else begin
                rx_n  = rx_shift;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(DATA_W + 1)) begin
                    rxv_n   = 1'b1;
                    tmo_n   = '0;
                    state_n = DONE;
                    if (cmd == 2'b10) seen_n = 1'b1;
                    else if (cmd == 2'b11 && rd_addr_seen) begin
                        seen_n  = 1'b0;
                        state_n = WAIT_TX;
                    end else if (cmd == 2'b11) err_n = 1'b1;
                end
            end
            WAIT_TX: if (SS_n) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else if (tx_valid) begin
                sh_n    = tx_data;
                oe_n    = 1'b1;
                cnt_n   = '0;
                state_n = TX;
            end else if (tmo == TW'(TX_TIMEOUT - 1)) begin
                err_n   = 1'b1;
                state_n = DONE;
            end else tmo_n = tmo + TW'(1);
            TX: if (SS_n) begin
                oe_n    = 1'b0;
                err_n   = 1'b1;
                state_n = IDLE;
            end else if (cnt == CW'(DATA_W - 1)) begin
                oe_n    = 1'b0;
                state_n = DONE;
            end else begin
                sh_n  = sh << 1;
                cnt_n = cnt + CW'(1);
            end
            DONE: state_n = SS_n ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tmo          <= '0;
            rx_data      <= '0;
            sh           <= '0;
            miso_oe      <= 1'b0;
            rd_addr_seen <= 1'b0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            tmo          <= tmo_n;
            rx_data      <= rx_n;
            sh           <= sh_n;
            miso_oe      <= oe_n;
            rd_addr_seen <= seen_n;
            rx_valid     <= rxv_n;
            frame_err    <= err_n;
            if (err_n && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed self-checking bench; a second instance with ERR_W=2 covers counter saturation.
module tb_spi_slave_ctrl;
    logic       clk = 1'b0, rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       MISO, miso_oe, rx_valid, busy, frame_err;
    logic [9:0] rx_data;
    logic [7:0] err_cnt;
    logic       MISO2, miso_oe2, rx_valid2, busy2, frame_err2;
    logic [9:0] rx_data2;
    logic [1:0] err_cnt2;
    int         n_chk = 0, n_fail = 0;
    logic [7:0] exp_byte;
    logic [4:0] part;

    spi_slave_ctrl u1 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .miso_oe(miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    spi_slave_ctrl #(.ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO2), .miso_oe(miso_oe2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy2), .frame_err(frame_err2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [9:0] f);
        SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            tick();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miso", MISO, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_frame_err", frame_err, 0);

        // write address
        frame(10'h0A5);
        chk("wa_rx_valid", rx_valid, 1);
        chk("wa_rx_data", rx_data, 10'h0A5);
        chk("wa_frame_err", frame_err, 0);
        chk("wa_busy", busy, 1);
        tick();
        chk("wa_rx_valid_pulse", rx_valid, 0);
        chk("wa_busy_done", busy, 1);
        end_frame();
        chk("wa_busy_idle", busy, 0);

        // read address then read data
        frame(10'h230);
        chk("ra_rx_valid", rx_valid, 1);
        chk("ra_rx_data", rx_data, 10'h230);
        end_frame();
        frame(10'h3FF);
        chk("rd_rx_valid", rx_valid, 1);
        chk("rd_frame_err", frame_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_oe", miso_oe, 0);
        end
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        exp_byte = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            chk("tx_oe", miso_oe, 1);
            chk("tx_miso", MISO, exp_byte[i]);
            chk("tx_frame_err", frame_err, 0);
            tick();
        end
        chk("tx_end_oe", miso_oe, 0);
        chk("tx_end_miso", MISO, 0);
        chk("tx_end_busy", busy, 1);
        end_frame();
        chk("tx_err_cnt", err_cnt, 0);

        // read data without read address
        frame(10'h300);
        chk("nra_rx_valid", rx_valid, 1);
        chk("nra_frame_err", frame_err, 1);
        chk("nra_err_cnt", err_cnt, 1);
        chk("nra_oe", miso_oe, 0);
        chk("nra_miso", MISO, 0);
        tick();
        chk("nra_err_pulse", frame_err, 0);
        chk("nra_oe2", miso_oe, 0);
        end_frame();

        // tx_valid timeout
        frame(10'h200);
        end_frame();
        frame(10'h3AA);
        chk("to_rx_valid", rx_valid, 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("to_frame_err", frame_err, k == 16);
            chk("to_oe", miso_oe, 0);
        end
        chk("to_err_cnt", err_cnt, 2);
        chk("to_busy", busy, 1);
        tick();
        chk("to_err_pulse", frame_err, 0);
        end_frame();

        // mid-frame abort after 5 bits
        SS_n = 1'b0;
        tick();
        part = 5'b01010;
        for (int i = 4; i >= 0; i--) begin
            MOSI = part[i];
            tick();
        end
        SS_n = 1'b1;
        tick();
        chk("ab_frame_err", frame_err, 1);
        chk("ab_rx_valid", rx_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_rx_data", rx_data, 10'h14A);
        chk("ab_err_cnt", err_cnt, 3);
        frame(10'h1F0);
        chk("ab_next_rx_valid", rx_valid, 1);
        chk("ab_next_rx_data", rx_data, 10'h1F0);
        chk("ab_next_frame_err", frame_err, 0);
        end_frame();

        // saturation with ERR_W=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("sat_rst_cnt", err_cnt, 0);
        chk("sat_rst_cnt2", err_cnt2, 0);
        for (int k = 1; k <= 5; k++) begin
            SS_n = 1'b0;
            tick();
            MOSI = 1'b1;
            tick();
            SS_n = 1'b1;
            tick();
            chk("sat_cnt2", err_cnt2, (k > 3) ? 3 : k);
        end
        chk("sat_cnt", err_cnt, 5);

        // asynchronous reset in the middle of TX
        frame(10'h201);
        end_frame();
        frame(10'h3C0);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        chk("mid_tx_oe", miso_oe, 1);
        chk("mid_tx_miso", MISO, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_miso", MISO, 0);
        chk("arst_oe", miso_oe, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_err_cnt2", err_cnt2, 0);
        chk("arst_busy", busy, 0);
        chk("arst_oe2", miso_oe2, 0);
        tick();
        rst = 1'b0;
        SS_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        frame(10'h300);
        chk("post_rst_frame_err", frame_err, 1);
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
